// File: rtl/fft_pkg.sv
// Shared FFT definitions: default data/twiddle widths, complex sample type,
// signed saturation and bit-reversal helpers.
package fft_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TWID_W = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Clamp v to the signed w-bit range; the caller narrows the result to w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int unsigned bitrev(input int unsigned v, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < nbits; i++) begin
            r = (r << 1) | ((v >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/r2sdf_bf_stage_if.sv
// Streaming sample bus of one R2SDF stage: input sample with start marker,
// registered output sample with start marker and natural-order bin index.
interface r2sdf_bf_stage_if #(
    parameter int unsigned N = 3,
    parameter int unsigned W = fft_pkg::DATA_W
) ();

    logic                start_ip;
    logic signed [W-1:0] ip_re;
    logic signed [W-1:0] ip_im;
    logic signed [W-1:0] op_re;
    logic signed [W-1:0] op_im;
    logic                start_op;
    logic [N-1:0]        op_idx;

    modport master (
        output start_ip, ip_re, ip_im,
        input  op_re, op_im, start_op, op_idx
    );

    modport slave (
        input  start_ip, ip_re, ip_im,
        output op_re, op_im, start_op, op_idx
    );

endinterface

// File: rtl/gen_shuffle_idx.sv
// Constant 2^N-entry bit-reversal table; maps the output position counter
// to the natural-order bin index.
module gen_shuffle_idx
    import fft_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] addr,
    output logic [N-1:0] idx
);

    localparam int unsigned SIZE = 1 << N;

    logic [N-1:0] tab [SIZE];

    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            tab[i] = N'(bitrev(i, N));
        end
    end

    assign idx = tab[addr];

endmodule

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage n of a 2^N-point
// streaming FFT: one complex sample per clock through a D = 2^(N-n) feedback line.
module r2sdf_bf_stage
    import fft_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned n  = 1,
    parameter int unsigned W  = DATA_W,
    parameter int unsigned TW = TWID_W
) (
    input  logic                     clk,
    input  logic                     rst,
    r2sdf_bf_stage_if.slave          bus,
    input  logic [TW*(1<<(N-1))-1:0] cos_tab,
    input  logic [TW*(1<<(N-1))-1:0] sin_tab
);

    localparam int unsigned D   = 1 << (N - n);
    localparam int unsigned CW  = N - n + 1;
    localparam int unsigned NT  = 1 << (N - 1);
    localparam int unsigned TIW = (N > 1) ? N - 1 : 1;
    localparam int unsigned SW  = W + 1;
    localparam int unsigned PW  = W + TW + 1;

    logic signed [TW-1:0] cos_e [NT];
    logic signed [TW-1:0] sin_e [NT];

    for (genvar g = 0; g < NT; g++) begin : g_tab
        assign cos_e[g] = cos_tab[g*TW +: TW];
        assign sin_e[g] = sin_tab[g*TW +: TW];
    end

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        pos;
    logic                 run;
    logic                 pend;
    logic                 active;
    logic                 phase_b;
    logic                 fire;
    logic [TIW-1:0]       tw_sel;
    logic signed [W-1:0]  dl_re [D];
    logic signed [W-1:0]  dl_im [D];
    logic signed [W-1:0]  head_re;
    logic signed [W-1:0]  head_im;
    logic signed [W-1:0]  op_re_d;
    logic signed [W-1:0]  op_im_d;
    logic signed [W-1:0]  push_re;
    logic signed [W-1:0]  push_im;
    logic signed [W-1:0]  op_re_q;
    logic signed [W-1:0]  op_im_q;
    logic                 start_q;
    logic [N-1:0]         ocnt;
    logic [N-1:0]         idx_w;
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic signed [SW-1:0] dif_re;
    logic signed [SW-1:0] dif_im;
    logic signed [PW-1:0] dr;
    logic signed [PW-1:0] di;
    logic signed [PW-1:0] c;
    logic signed [PW-1:0] s;
    logic signed [PW-1:0] pr_re;
    logic signed [PW-1:0] pr_im;

    always_comb begin
        // A start pulse makes the sample at this edge position 0 of a new block.
        active  = bus.start_ip | run;
        pos     = bus.start_ip ? '0 : cnt;
        phase_b = pos[CW-1];
        fire    = pend && (pos == CW'(D));
        tw_sel  = TIW'((N'(pos) - N'(D)) << (n - 1));

        head_re = dl_re[D-1];
        head_im = dl_im[D-1];
        sum_re  = SW'(head_re) + SW'(bus.ip_re);
        sum_im  = SW'(head_im) + SW'(bus.ip_im);
        dif_re  = SW'(head_re) - SW'(bus.ip_re);
        dif_im  = SW'(head_im) - SW'(bus.ip_im);

        // (a - b) * conj(Wk), floored back to the data scale.
        dr    = PW'(dif_re);
        di    = PW'(dif_im);
        c     = PW'(cos_e[tw_sel]);
        s     = PW'(sin_e[tw_sel]);
        pr_re = (dr * c + di * s) >>> (TW - 2);
        pr_im = (di * c - dr * s) >>> (TW - 2);

        op_re_d = head_re;
        op_im_d = head_im;
        push_re = bus.ip_re;
        push_im = bus.ip_im;
        if (phase_b) begin
            op_re_d = W'(sat(64'(sum_re), W));
            op_im_d = W'(sat(64'(sum_im), W));
            push_re = W'(sat(64'(pr_re), W));
            push_im = W'(sat(64'(pr_im), W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            run     <= 1'b0;
            pend    <= 1'b0;
            start_q <= 1'b0;
            ocnt    <= '0;
            op_re_q <= '0;
            op_im_q <= '0;
            for (int unsigned i = 0; i < D; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else begin
            start_q <= fire;
            if (active) begin
                cnt      <= pos + 1'b1;
                run      <= 1'b1;
                op_re_q  <= op_re_d;
                op_im_q  <= op_im_d;
                dl_re[0] <= push_re;
                dl_im[0] <= push_im;
                for (int unsigned i = 1; i < D; i++) begin
                    dl_re[i] <= dl_re[i-1];
                    dl_im[i] <= dl_im[i-1];
                end
            end else begin
                op_re_q <= '0;
                op_im_q <= '0;
            end
            if (bus.start_ip) begin
                pend <= 1'b1;
            end else if (fire) begin
                pend <= 1'b0;
            end
            if (fire) begin
                ocnt <= '0;
            end else if (run) begin
                ocnt <= ocnt + 1'b1;
            end
        end
    end

    gen_shuffle_idx #(.N(N)) u_idx (
        .addr (ocnt),
        .idx  (idx_w)
    );

    assign bus.op_re    = op_re_q;
    assign bus.op_im    = op_im_q;
    assign bus.start_op = start_q;
    assign bus.op_idx   = idx_w;

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Directed bench for r2sdf_bf_stage: single stage N=3/n=1 plus a three-stage chain.
module tb_r2sdf_bf_stage;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] cos_tab;
    logic [63:0] sin_tab;
    logic [63:0] cos_tr;
    logic [63:0] sin_tr;

    int cos_v[4] = '{16384, 11585, 0, -11585};
    int sin_v[4] = '{0, 11585, 16384, 11585};
    int brv[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};

    r2sdf_bf_stage_if #(.N(3), .W(16)) b1 ();
    r2sdf_bf_stage_if #(.N(3), .W(16)) ci1 ();
    r2sdf_bf_stage_if #(.N(3), .W(16)) ci2 ();
    r2sdf_bf_stage_if #(.N(3), .W(16)) ci3 ();

    r2sdf_bf_stage #(.N(3), .n(1), .W(16), .TW(16)) dut (
        .clk(clk), .rst(rst), .bus(b1), .cos_tab(cos_tab), .sin_tab(sin_tab));

    r2sdf_bf_stage #(.N(3), .n(1), .W(16), .TW(16)) st1 (
        .clk(clk), .rst(rst), .bus(ci1), .cos_tab(cos_tr), .sin_tab(sin_tr));
    r2sdf_bf_stage #(.N(3), .n(2), .W(16), .TW(16)) st2 (
        .clk(clk), .rst(rst), .bus(ci2), .cos_tab(cos_tr), .sin_tab(sin_tr));
    r2sdf_bf_stage #(.N(3), .n(3), .W(16), .TW(16)) st3 (
        .clk(clk), .rst(rst), .bus(ci3), .cos_tab(cos_tr), .sin_tab(sin_tr));

    assign ci2.start_ip = ci1.start_op;
    assign ci2.ip_re    = ci1.op_re;
    assign ci2.ip_im    = ci1.op_im;
    assign ci3.start_ip = ci2.start_op;
    assign ci3.ip_re    = ci2.op_re;
    assign ci3.ip_im    = ci2.op_im;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit start, input int re, input int im);
        b1.start_ip = start;
        b1.ip_re    = 16'(re);
        b1.ip_im    = 16'(im);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 0, 0);
        ci1.start_ip = 1'b0;
        ci1.ip_re    = '0;
        ci1.ip_im    = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 4; i++) begin
            cos_tab[16*i +: 16] = 16'd16384;
            sin_tab[16*i +: 16] = 16'd0;
        end
    endtask

    task automatic set_true();
        cos_tab = cos_tr;
        sin_tab = sin_tr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5, 3);
        step();
        checks++; if (b1.op_re !== 16'sd0) begin failures++; $display("FAIL reset_op_re got %0d expected 0", b1.op_re); end
        checks++; if (b1.op_im !== 16'sd0) begin failures++; $display("FAIL reset_op_im got %0d expected 0", b1.op_im); end
        checks++; if (b1.start_op !== 1'b0) begin failures++; $display("FAIL reset_start_op got %0b expected 0", b1.start_op); end
        checks++; if (b1.op_idx !== 3'd0) begin failures++; $display("FAIL reset_op_idx got %0d expected 0", b1.op_idx); end
        rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            drive(1'b0, 7, 7);
            step();
            checks++;
            if (b1.op_re !== 16'sd0 || b1.start_op !== 1'b0) begin
                failures++;
                $display("FAIL reset_wins e=%0d got op_re=%0d start_op=%0b expected 0/0", e, b1.op_re, b1.start_op);
            end
        end
    endtask

    task automatic test_ramp();
        int er;
        do_reset();
        set_identity();
        for (int e = 0; e < 12; e++) begin
            drive(e == 0, (e < 8) ? e + 1 : 0, 0);
            step();
            er = (e < 4) ? 0 : (e < 8) ? 2 * e - 2 : -4;
            checks++; if (b1.op_re !== 16'(er)) begin failures++; $display("FAIL ramp_re e=%0d got %0d expected %0d", e, b1.op_re, er); end
            checks++; if (b1.op_im !== 16'sd0) begin failures++; $display("FAIL ramp_im e=%0d got %0d expected 0", e, b1.op_im); end
            checks++; if (b1.start_op !== (e == 4)) begin failures++; $display("FAIL ramp_start_op e=%0d got %0b expected %0b", e, b1.start_op, e == 4); end
            if (e >= 4) begin
                checks++;
                if (b1.op_idx !== 3'(brv[e-4])) begin failures++; $display("FAIL ramp_idx e=%0d got %0d expected %0d", e, b1.op_idx, brv[e-4]); end
            end
        end
    endtask

    task automatic test_twiddle();
        int er, ei, dr, di;
        do_reset();
        set_true();
        for (int e = 0; e < 12; e++) begin
            drive(e == 0, (e < 8) ? e + 1 : 0, 0);
            step();
            er = 0;
            ei = 0;
            if (e >= 4 && e < 8) begin
                er = 2 * e - 2;
            end else if (e >= 8) begin
                dr = (e - 7) - (e - 3);
                di = 0;
                er = sat16((dr * cos_v[e-8] + di * sin_v[e-8]) >>> 14);
                ei = sat16((di * cos_v[e-8] - dr * sin_v[e-8]) >>> 14);
            end
            checks++; if (b1.op_re !== 16'(er)) begin failures++; $display("FAIL twiddle_re e=%0d got %0d expected %0d", e, b1.op_re, er); end
            checks++; if (b1.op_im !== 16'(ei)) begin failures++; $display("FAIL twiddle_im e=%0d got %0d expected %0d", e, b1.op_im, ei); end
        end
    endtask

    task automatic test_saturation();
        cplx_t in_v[12];
        cplx_t ex_v[8];
        for (int i = 0; i < 12; i++) in_v[i] = '0;
        for (int i = 0; i < 8; i++) ex_v[i] = '0;
        in_v[0] = '{re: 16'sh7FFF, im: 16'sh7FFF};
        in_v[1] = '{re: 16'sh8000, im: 16'sh8000};
        in_v[2] = '{re: 16'sh7FFF, im: 16'sh8000};
        in_v[4] = '{re: 16'sh7FFF, im: 16'sh7FFF};
        in_v[5] = '{re: 16'sh8000, im: 16'sh8000};
        in_v[6] = '{re: 16'sh8000, im: 16'sh7FFF};
        ex_v[0] = '{re: 16'sh7FFF, im: 16'sh7FFF};
        ex_v[1] = '{re: 16'sh8000, im: 16'sh8000};
        ex_v[2] = '{re: -16'sd1,   im: -16'sd1};
        ex_v[6] = '{re: 16'sh7FFF, im: 16'sh8000};
        do_reset();
        set_identity();
        for (int e = 0; e < 12; e++) begin
            drive(e == 0, in_v[e].re, in_v[e].im);
            step();
            if (e >= 4) begin
                checks++; if (b1.op_re !== ex_v[e-4].re) begin failures++; $display("FAIL sat_re e=%0d got %0d expected %0d", e, b1.op_re, ex_v[e-4].re); end
                checks++; if (b1.op_im !== ex_v[e-4].im) begin failures++; $display("FAIL sat_im e=%0d got %0d expected %0d", e, b1.op_im, ex_v[e-4].im); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_identity();
        for (int e = 0; e < 6; e++) begin
            drive(e == 0, e + 1, e + 1);
            rst = (e == 5);
            step();
        end
        checks++; if (b1.op_re !== 16'sd0) begin failures++; $display("FAIL midrst_op_re got %0d expected 0", b1.op_re); end
        checks++; if (b1.op_im !== 16'sd0) begin failures++; $display("FAIL midrst_op_im got %0d expected 0", b1.op_im); end
        checks++; if (b1.start_op !== 1'b0) begin failures++; $display("FAIL midrst_start_op got %0b expected 0", b1.start_op); end
        checks++; if (b1.op_idx !== 3'd0) begin failures++; $display("FAIL midrst_op_idx got %0d expected 0", b1.op_idx); end
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            drive(1'b0, 0, 0);
            step();
            checks++;
            if (b1.op_re !== 16'sd0 || b1.op_im !== 16'sd0) begin
                failures++;
                $display("FAIL midrst_flush e=%0d got %0d/%0d expected 0/0", e, b1.op_re, b1.op_im);
            end
        end
    endtask

    task automatic test_restart();
        int exp_re[4] = '{1, 2, 3, 12};
        do_reset();
        set_identity();
        for (int e = 0; e < 9; e++) begin
            drive(e == 0 || e == 3, e + 1, 0);
            step();
            if (e >= 1) begin
                checks++;
                if (b1.start_op !== (e == 7)) begin failures++; $display("FAIL restart_start_op e=%0d got %0b expected %0b", e, b1.start_op, e == 7); end
            end
            if (e >= 4 && e < 8) begin
                checks++;
                if (b1.op_re !== 16'(exp_re[e-4])) begin failures++; $display("FAIL restart_re e=%0d got %0d expected %0d", e, b1.op_re, exp_re[e-4]); end
            end
        end
    endtask

    task automatic test_chain();
        bit found;
        do_reset();
        ci1.start_ip = 1'b1;
        ci1.ip_re    = 16'sd100;
        ci1.ip_im    = 16'sd0;
        step();
        ci1.start_ip = 1'b0;
        ci1.ip_re    = '0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (ci3.start_op === 1'b1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL chain_start_op got no pulse within 30 cycles expected one");
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++; if (ci3.op_re !== 16'sd100) begin failures++; $display("FAIL chain_re j=%0d got %0d expected 100", j, ci3.op_re); end
                checks++; if (ci3.op_im !== 16'sd0) begin failures++; $display("FAIL chain_im j=%0d got %0d expected 0", j, ci3.op_im); end
                checks++; if (ci3.op_idx !== 3'(brv[j])) begin failures++; $display("FAIL chain_idx j=%0d got %0d expected %0d", j, ci3.op_idx, brv[j]); end
                checks++; if (ci3.start_op !== (j == 0)) begin failures++; $display("FAIL chain_pulse j=%0d got %0b expected %0b", j, ci3.start_op, j == 0); end
                step();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cos_tr[16*i +: 16] = 16'(cos_v[i]);
            sin_tr[16*i +: 16] = 16'(sin_v[i]);
        end
        cos_tab = '0;
        sin_tab = '0;
        rst = 1'b1;
        drive(1'b0, 0, 0);
        ci1.start_ip = 1'b0;
        ci1.ip_re    = '0;
        ci1.ip_im    = '0;
        set_identity();
        test_reset();
        test_ramp();
        test_twiddle();
        test_saturation();
        test_reset_mid();
        test_restart();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
